// File: rtl/div_reconstruct_if.sv
// Handshake bundle for the dividend-reconstruction unit: operand channel in,
// result channel out, each with its own valid/ready pair.
interface div_reconstruct_if;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] quot;
   logic [2:0] divisor;
   logic [4:0] rem;
   logic       out_valid;
   logic       out_ready;
   logic [4:0] dividend;
   logic       out_of_range;
   logic       err_inconsistent;
   logic       err_divzero;

   modport master (
      output in_valid, quot, divisor, rem, out_ready,
      input  in_ready, out_valid, dividend, out_of_range, err_inconsistent, err_divzero
   );

   modport slave (
      input  in_valid, quot, divisor, rem, out_ready,
      output in_ready, out_valid, dividend, out_of_range, err_inconsistent, err_divzero
   );
endinterface

// File: rtl/div_reconstruct.sv
// Rebuilds a dividend from sign-magnitude quotient, divisor and remainder as
// |q|*|b| + |r| with a 2-step shift-add multiply, flagging impossible operand sets.
module div_reconstruct #(
   parameter bit LAT_FIXED = 1'b1
) (
   input logic              clk,
   input logic              rst,
   div_reconstruct_if.slave bus
);

   typedef enum logic [2:0] {S_IDLE, S_MUL0, S_MUL1, S_ADD, S_DONE} state_e;

   state_e     state_q, state_d;
   logic [2:0] quot_q, quot_d;
   logic [2:0] div_q, div_d;
   logic [4:0] rem_q, rem_d;
   logic [3:0] acc_q, acc_d;
   logic [4:0] dividend_q, dividend_d;
   logic       oor_q, oor_d;
   logic       inc_q, inc_d;
   logic       dz_q, dz_d;

   logic       accept;
   logic [3:0] sum;
   logic       sign;
   logic       div_zero;

   // A remainder can only come from a legal divide if it is padded correctly,
   // smaller than the divisor and shares the quotient's sign whenever both are nonzero.
   function automatic logic calc_inconsistent(input logic [2:0] q,
                                              input logic [2:0] d,
                                              input logic [4:0] r);
      logic bad_pad;
      logic rem_too_big;
      logic sign_clash;
      bad_pad     = (r[3:2] != 2'b00);
      rem_too_big = (d[1:0] != 2'b00) && (r[1:0] >= d[1:0]);
      sign_clash  = (q[1:0] != 2'b00) && (r[1:0] != 2'b00) && (r[4] != (q[2] ^ d[2]));
      return bad_pad || rem_too_big || sign_clash;
   endfunction

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      state_d    = state_q;
      quot_d     = quot_q;
      div_d      = div_q;
      rem_d      = rem_q;
      acc_d      = acc_q;
      dividend_d = dividend_q;
      oor_d      = oor_q;
      inc_d      = inc_q;
      dz_d       = dz_q;

      accept   = bus.in_valid && (state_q == S_IDLE);
      sum      = acc_q + {2'b00, rem_q[1:0]};
      div_zero = (div_q[1:0] == 2'b00);
      if (sum == 4'd0)               sign = 1'b0;
      else if (quot_q[1:0] != 2'b00) sign = quot_q[2] ^ div_q[2];
      else                           sign = rem_q[4];

      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               quot_d = bus.quot;
               div_d  = bus.divisor;
               rem_d  = bus.rem;
               if (!LAT_FIXED && (bus.divisor[1:0] == 2'b00)) begin
                  // Divide-by-zero result is fully known from the inputs.
                  dividend_d = 5'b00000;
                  oor_d      = 1'b0;
                  dz_d       = 1'b1;
                  inc_d      = calc_inconsistent(bus.quot, bus.divisor, bus.rem);
                  state_d    = S_DONE;
               end else begin
                  state_d = S_MUL0;
               end
            end
         end
         S_MUL0: begin
            acc_d   = quot_q[0] ? {2'b00, div_q[1:0]} : 4'd0;
            state_d = S_MUL1;
         end
         S_MUL1: begin
            acc_d   = acc_q + (quot_q[1] ? {1'b0, div_q[1:0], 1'b0} : 4'd0);
            state_d = S_ADD;
         end
         S_ADD: begin
            acc_d      = sum;
            dz_d       = div_zero;
            dividend_d = div_zero ? 5'b00000 : {sign, sum};
            oor_d      = !div_zero && (sum > 4'd3);
            inc_d      = calc_inconsistent(quot_q, div_q, rem_q);
            state_d    = S_DONE;
         end
         S_DONE: begin
            if (bus.out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         quot_q     <= '0;
         div_q      <= '0;
         rem_q      <= '0;
         acc_q      <= '0;
         dividend_q <= '0;
         oor_q      <= 1'b0;
         inc_q      <= 1'b0;
         dz_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         quot_q     <= quot_d;
         div_q      <= div_d;
         rem_q      <= rem_d;
         acc_q      <= acc_d;
         dividend_q <= dividend_d;
         oor_q      <= oor_d;
         inc_q      <= inc_d;
         dz_q       <= dz_d;
      end
   end

   assign bus.in_ready         = (state_q == S_IDLE);
   assign bus.out_valid        = (state_q == S_DONE);
   assign bus.dividend         = dividend_q;
   assign bus.out_of_range     = oor_q;
   assign bus.err_inconsistent = inc_q;
   assign bus.err_divzero      = dz_q;

endmodule
